vga_timing_gen: RTL and testbench

Raster timing generator that produces the DrawX/DrawY/blank scan interface consumed by the background, sprite and palette renderers. It also drives hs/vs to the VGA connector. All downstream pixel modules use its outputs as the sole frame-position reference. Default timing is 640x480@60 Hz (800x525 total), with an optional clock divider for running from a faster system clock.

---
 rtl/vga_scan_if.sv | 22 ++
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vga_scan_if.sv
// Raster scan bundle from the timing generator to the pixel renderers.
// The generator drives through master; renderers and VGA pins read through slave.
interface vga_scan_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       pixel_en;
  logic       line_start;
  logic       frame_start;

  modport master (
    output DrawX, DrawY, blank, hs, vs,
    output pixel_en, line_start, frame_start
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs,
    input pixel_en, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (DrawX/DrawY/blank/hs/vs plus strobes).
// Define VGA_SYNC_ALIGN_EN to delay hs/vs/blank by SYNC_DELAY extra stages.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 1,
  parameter int SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  vga_scan_if.master scan
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] HV    = 10'(H_VISIBLE);
  localparam logic [9:0] VV    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_LO = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_HI = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_LO = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_HI = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_M1 = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1 || SYNC_DELAY < 1) begin : g_bad_cfg
    $error("vga_timing_gen: CLK_DIV and SYNC_DELAY must be >= 1");
  end

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    hc_q, hc_d;
  logic [9:0]    vc_q, vc_d;
  logic          tick;

  logic [9:0] x_q, y_q;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       pe_q, ls_q, fs_q;
  logic       ls_d, fs_d;

  assign tick = (div_q == DIV_M1);

  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (tick) begin
      if (hc_q == HT_M1) begin
        hc_d = '0;
        vc_d = (vc_q == VT_M1) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  always_comb begin
    blank_d = (hc_q < HV) && (vc_q < VV);
    hs_d    = !((hc_q >= HS_LO) && (hc_q < HS_HI));
    vs_d    = !((vc_q >= VS_LO) && (vc_q < VS_HI));
    ls_d    = tick && (hc_q == '0);
    fs_d    = ls_d && (vc_q == '0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
    end
  end

  // Outputs sample the pre-update counters, so they trail hc/vc by one clock.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= '0;
      y_q     <= '0;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      pe_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      x_q     <= hc_q;
      y_q     <= vc_q;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      pe_q    <= tick;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign scan.DrawX       = x_q;
  assign scan.DrawY       = y_q;
  assign scan.pixel_en    = pe_q;
  assign scan.line_start  = ls_q;
  assign scan.frame_start = fs_q;

`ifdef VGA_SYNC_ALIGN_EN
  logic [2:0] dly_q [SYNC_DELAY];

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_DELAY; i++) begin
        dly_q[i] <= 3'b011;
      end
    end else begin
      dly_q[0] <= {blank_q, hs_q, vs_q};
      for (int i = 1; i < SYNC_DELAY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign scan.blank = dly_q[SYNC_DELAY-1][2];
  assign scan.hs    = dly_q[SYNC_DELAY-1][1];
  assign scan.vs    = dly_q[SYNC_DELAY-1][0];
`else
  assign scan.blank = blank_q;
  assign scan.hs    = hs_q;
  assign scan.vs    = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default 640x480 instance plus a tiny CLK_DIV=2 instance.
// Expected scan vectors come from closed-form edge-index arithmetic.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  always #5 clk = ~clk;

  vga_scan_if s0 ();
  vga_scan_if s1 ();

  vga_timing_gen u_dut0 (
    .vga_clk (clk),
    .reset_n (rst0_n),
    .scan    (s0)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_VISIBLE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .CLK_DIV   (2), .SYNC_DELAY (2)
  ) u_dut1 (
    .vga_clk (clk),
    .reset_n (rst1_n),
    .scan    (s1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {DrawX, DrawY, blank, hs, vs, pixel_en, line_start, frame_start}
  function automatic logic [25:0] exp_vec(
    int k, int hv, int hf, int hsy, int ht,
    int vv, int vf, int vsy, int vt, int d);
    int m, t, hc, vc, m2, t2, hc2, vc2;
    logic tick, b, hs, vs, ls, fs;
    m    = k - 1;
    t    = m / d;
    hc   = t % ht;
    vc   = (t / ht) % vt;
    tick = ((m % d) == d - 1);
    ls   = tick && (hc == 0);
    fs   = ls && (vc == 0);
    if (k <= SD) begin
      b = 1'b0; hs = 1'b1; vs = 1'b1;
    end else begin
      m2  = k - 1 - SD;
      t2  = m2 / d;
      hc2 = t2 % ht;
      vc2 = (t2 / ht) % vt;
      b   = (hc2 < hv) && (vc2 < vv);
      hs  = !((hc2 >= hv + hf) && (hc2 < hv + hf + hsy));
      vs  = !((vc2 >= vv + vf) && (vc2 < vv + vf + vsy));
    end
    return {10'(hc), 10'(vc), b, hs, vs, tick, ls, fs};
  endfunction

  logic [25:0] vec0, vec1;
  assign vec0 = {s0.DrawX, s0.DrawY, s0.blank, s0.hs, s0.vs,
                 s0.pixel_en, s0.line_start, s0.frame_start};
  assign vec1 = {s1.DrawX, s1.DrawY, s1.blank, s1.hs, s1.vs,
                 s1.pixel_en, s1.line_start, s1.frame_start};

  logic [25:0] rst_vec;
  assign rst_vec = {20'd0, 3'b011, 3'b000};

  logic [25:0] q0[$];
  logic [25:0] q1[$];
  bit act0 = 0, act1 = 0;
  int k0 = 0, k1 = 0;
  int hs0_low = 0, bl0_cnt = 0;
  int vs1_low = 0, pe1_cnt = 0;
  int fs1_k[$];

  always @(posedge clk) begin
    if (act0) begin
      k0++;
      q0.push_back(exp_vec(k0, 640, 16, 96, 800, 480, 10, 2, 525, 1));
    end
    if (act1) begin
      k1++;
      q1.push_back(exp_vec(k1, 8, 2, 3, 15, 6, 1, 2, 10, 2));
    end
  end

  always @(negedge clk) begin
    logic [25:0] e;
    if (act0 && q0.size() > 0) begin
      e = q0.pop_front();
      chk("scan0", 32'(vec0), 32'(e));
      if (!s0.hs) hs0_low++;
      if (s0.blank) bl0_cnt++;
    end
    if (act1 && q1.size() > 0) begin
      e = q1.pop_front();
      chk("scan1", 32'(vec1), 32'(e));
      if (!s1.vs) vs1_low++;
      if (s1.pixel_en) pe1_cnt++;
      if (s1.frame_start) fs1_k.push_back(k1);
    end
  end

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst0_init", 32'(vec0), 32'(rst_vec));
    chk("rst1_init", 32'(vec1), 32'(rst_vec));

    @(negedge clk);
    rst0_n = 1'b1;
    act0   = 1'b1;
    repeat (1901) @(posedge clk);
    @(negedge clk);
    #2;
    chk("mid_x", 32'(s0.DrawX), 32'd300);
    chk("mid_y", 32'(s0.DrawY), 32'd2);
    chk("hs0_low", 32'(hs0_low), 32'd192);
    chk("blank0_cnt", 32'(bl0_cnt), 32'(1581 - SD));
    rst0_n = 1'b0;
    act0   = 1'b0;
    #1;
    chk("rst0_mid", 32'(vec0), 32'(rst_vec));
    q0.delete();

    @(negedge clk);
    rst1_n = 1'b1;
    act1   = 1'b1;
    repeat (650) @(posedge clk);
    @(negedge clk);
    #2;
    chk("fs1_count", 32'(fs1_k.size()), 32'd3);
    if (fs1_k.size() == 3) begin
      chk("fs1_first", 32'(fs1_k[0]), 32'd2);
      chk("fs1_period_a", 32'(fs1_k[1] - fs1_k[0]), 32'd300);
      chk("fs1_period_b", 32'(fs1_k[2] - fs1_k[1]), 32'd300);
    end
    chk("vs1_low", 32'(vs1_low), 32'd120);
    chk("pe1_cnt", 32'(pe1_cnt), 32'd325);
    rst1_n = 1'b0;
    act1   = 1'b0;
    #1;
    chk("rst1_mid", 32'(vec1), 32'(rst_vec));
    q1.delete();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
